// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module   : imem_port_arbiter
// Brief    : Byte-wide instruction memory with a shared port. Big-endian
//            multi-byte fetches and single-byte loads are arbitrated
//            round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
    parameter int REG_BITS  = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [REG_BITS-1:0]  fetch_addr,
    output logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [REG_BITS-1:0]  fetch_instr,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 load_ready,
    output logic                 busy
);

    localparam int                c_nb       = REG_BITS / 8;
    localparam int                c_cnt_w    = 2;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_nb - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_BITS-1:0]   r_base;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [REG_BITS-1:0]    r_asm;
    logic [REG_BITS-1:0]    r_instr;
    logic                   r_prio_fetch;
    logic [7:0]             r_mem [DEPTH];

    logic [ADDR_BITS-1:0]   w_rd_addr;
    logic [7:0]             w_rd_byte;
    logic [REG_BITS-1:0]    w_asm_next;
    logic                   w_last_byte;
    logic                   w_unused_fetch_addr_hi;

    // Only the low address bits select a byte; the rest of the PC is ignored.
    assign w_unused_fetch_addr_hi = ^fetch_addr[REG_BITS-1:ADDR_BITS];

    assign w_rd_addr   = r_base + ADDR_BITS'(r_cnt);
    assign w_rd_byte   = r_mem[w_rd_addr];
    assign w_asm_next  = {r_asm[REG_BITS-9:0], w_rd_byte};
    assign w_last_byte = (r_state == S_FETCH) && (r_cnt == c_last_cnt);

    assign fetch_instr = r_instr;
    assign fetch_valid = (r_state == S_RESP) && !reset;
    assign busy        = (r_state != S_IDLE);

    // Grants are withheld while reset is high so no handshake can complete.
    always_comb begin
        w_state_next = r_state;
        fetch_ready  = 1'b0;
        load_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    if (fetch_req && (!load_valid || r_prio_fetch)) begin
                        fetch_ready = 1'b1;
                    end else if (load_valid) begin
                        load_ready = 1'b1;
                    end
                end
                if (fetch_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_cnt == c_last_cnt) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_cnt        <= '0;
            r_asm        <= '0;
            r_instr      <= '0;
            r_prio_fetch <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (fetch_ready) begin
                r_base       <= fetch_addr[ADDR_BITS-1:0];
                r_cnt        <= '0;
                r_prio_fetch <= 1'b0;
            end
            if (load_ready) begin
                r_prio_fetch <= 1'b1;
            end
            if (r_state == S_FETCH) begin
                r_asm <= w_asm_next;
                r_cnt <= r_cnt + 1'b1;
            end
            // The final byte lands in the assembly and the output together.
            if (w_last_byte) begin
                r_instr <= w_asm_next;
            end
        end
    end

    // Storage is deliberately outside reset so a reset never loses program bytes.
    always_ff @(posedge clk) begin
        if (load_ready && load_valid) begin
            r_mem[load_addr] <= load_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module   : tb_imem_port_arbiter
// Brief    : Directed self-checking bench for imem_port_arbiter (32- and
//            16-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ready;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        l_valid;
    logic [7:0]  l_addr;
    logic [7:0]  l_data;
    logic        l_ready;
    logic        busy;

    logic        h_req;
    logic [15:0] h_addr;
    logic        h_ready;
    logic        h_valid;
    logic [15:0] h_instr;
    logic        h_lvalid;
    logic [7:0]  h_laddr;
    logic [7:0]  h_ldata;
    logic        h_lready;
    logic        h_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.REG_BITS(32), .DEPTH(256), .ADDR_BITS(8)) dut32 (
        .clk(clk), .reset(reset),
        .fetch_req(f_req), .fetch_addr(f_addr), .fetch_ready(f_ready),
        .fetch_valid(f_valid), .fetch_instr(f_instr),
        .load_valid(l_valid), .load_addr(l_addr), .load_data(l_data),
        .load_ready(l_ready), .busy(busy)
    );

    imem_port_arbiter #(.REG_BITS(16), .DEPTH(256), .ADDR_BITS(8)) dut16 (
        .clk(clk), .reset(reset),
        .fetch_req(h_req), .fetch_addr(h_addr), .fetch_ready(h_ready),
        .fetch_valid(h_valid), .fetch_instr(h_instr),
        .load_valid(h_lvalid), .load_addr(h_laddr), .load_data(h_ldata),
        .load_ready(h_lready), .busy(h_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load32(input logic [7:0] addr, input logic [7:0] data);
        l_valid = 1'b1; l_addr = addr; l_data = data;
        #1 check("load_ready", 32'(l_ready), 32'd1);
        step();
        l_valid = 1'b0;
    endtask

    task automatic load16(input logic [7:0] addr, input logic [7:0] data);
        h_lvalid = 1'b1; h_laddr = addr; h_ldata = data;
        #1 check("load16_ready", 32'(h_lready), 32'd1);
        step();
        h_lvalid = 1'b0;
    endtask

    // Acceptance in cycle T; FETCH in T+1..T+4; fetch_valid in T+5; IDLE at T+6.
    task automatic fetch32(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        f_req = 1'b1; f_addr = addr;
        #1 check({tag, ".ready"}, 32'(f_ready), 32'd1);
        step();
        f_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1 check({tag, ".fetch_busy_valid"}, 32'({busy, f_valid}), 32'b10);
            step();
        end
        #1 check({tag, ".resp_busy_valid"}, 32'({busy, f_valid}), 32'b11);
        check({tag, ".instr"}, f_instr, exp);
        step();
        #1 check({tag, ".idle_busy_valid"}, 32'({busy, f_valid}), 32'b00);
    endtask

    logic [2:0] cont_exp [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        f_req = 1'b0; f_addr = '0; l_valid = 1'b0; l_addr = '0; l_data = '0;
        h_req = 1'b0; h_addr = '0; h_lvalid = 1'b0; h_laddr = '0; h_ldata = '0;
        step(); step();
        reset = 1'b0;

        // Reset state and first-cycle IDLE behaviour
        #1 check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(f_valid), 32'd0);
        check("rst_instr", f_instr, 32'd0);
        check("rst_instr16", 32'(h_instr), 32'd0);
        check("rst_ready_noreq", 32'({f_ready, l_ready}), 32'b00);
        f_req = 1'b1;
        #1 check("rst_fetch_ready", 32'(f_ready), 32'd1);
        f_req = 1'b0;
        step();

        // Basic big-endian fetch; fetch in the cycle right after the last load
        load32(8'h10, 8'hDE); load32(8'h11, 8'hAD);
        load32(8'h12, 8'hBE); load32(8'h13, 8'hEF);
        fetch32("basic", 32'h0000_0010, 32'hDEAD_BEEF);

        // Address wrap, with and without upper PC bits set
        load32(8'hFE, 8'h11); load32(8'hFF, 8'h22);
        load32(8'h00, 8'h33); load32(8'h01, 8'h44);
        fetch32("wrap", 32'h0000_00FE, 32'h1122_3344);
        fetch32("wrap_hi", 32'h0000_01FE, 32'h1122_3344);

        // Contention from reset: {fetch_ready, load_ready, fetch_valid} per cycle
        cont_exp = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010,
                     3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010,
                     3'b100};
        reset = 1'b1; f_req = 1'b1; f_addr = 32'h10; l_valid = 1'b1;
        l_addr = 8'h50; l_data = 8'h77;
        #1 check("cont_reset_no_handshake", 32'({f_ready, l_ready}), 32'b00);
        step();
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            #1 check($sformatf("cont_c%0d", c), 32'({f_ready, l_ready, f_valid}),
                     32'(cont_exp[c]));
            if (c == 5) check("cont_instr", f_instr, 32'hDEAD_BEEF);
            step();
        end
        f_req = 1'b0; l_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();
        #1 check("cont_back_idle", 32'(busy), 32'd0);

        // Reset in the second FETCH cycle aborts the transaction
        f_req = 1'b1; f_addr = 32'h10;
        #1 check("abort_accept", 32'(f_ready), 32'd1);
        step();
        f_req = 1'b0;
        step();
        reset = 1'b1;
        #1 check("abort_busy_mid", 32'(busy), 32'd1);
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check("abort_idle", 32'({busy, f_valid}), 32'b00);
            step();
        end
        check("abort_instr", f_instr, 32'd0);
        fetch32("refetch", 32'h10, 32'hDEAD_BEEF);

        // Eight back-to-back loads, no stalls
        l_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            l_addr = 8'(8'h60 + i); l_data = 8'(8'hA0 + i);
            #1 check($sformatf("b2b_ready%0d", i), 32'(l_ready), 32'd1);
            step();
        end
        l_valid = 1'b0;
        fetch32("b2b_lo", 32'h60, 32'hA0A1_A2A3);
        fetch32("b2b_hi", 32'h64, 32'hA4A5_A6A7);

        // 16-bit instance, misaligned fetch, valid at acceptance+3
        load16(8'h21, 8'hAB); load16(8'h22, 8'hCD);
        h_req = 1'b1; h_addr = 16'h0021;
        #1 check("h16_ready", 32'(h_ready), 32'd1);
        step();
        h_req = 1'b0;
        #1 check("h16_t1", 32'({h_busy, h_valid}), 32'b10);
        step();
        #1 check("h16_t2", 32'({h_busy, h_valid}), 32'b10);
        step();
        #1 check("h16_t3", 32'({h_busy, h_valid}), 32'b11);
        check("h16_instr", 32'(h_instr), 32'h0000_ABCD);
        step();
        #1 check("h16_t4", 32'({h_busy, h_valid}), 32'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and arbiter for the single-ported, byte-addressed instruction memory. It owns the 8-bit-wide storage array and shares its one byte-per-cycle port between two requesters. The CPU fetch path issues multi-byte instruction fetches, which the block assembles big-endian over several cycles. The program loader issues single-byte writes. It sits between the PC/fetch stage and the memory, replacing direct array access.

## Interface
- REG_BITS, 32: instruction width; only 32 or 16 are legal; NB = REG_BITS/8 bytes per fetch (4 or 2).
- DEPTH, 256: number of bytes in the array.
- ADDR_BITS, 8: byte address width, log2(DEPTH).

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  fetch request.
- fetch_addr  in  REG_BITS  byte address of the instruction's MSB byte; only the low ADDR_BITS are used.
- fetch_ready  out  1  fetch accepted this cycle when high together with fetch_req.
- fetch_valid  out  1  one-cycle pulse; fetch_instr is valid.
- fetch_instr  out  REG_BITS  assembled instruction; holds its value until the next completion.
- load_valid  in  1  byte write request.
- load_addr  in  ADDR_BITS  write byte address.
- load_data  in  8  write byte.
- load_ready  out  1  write performed this cycle when high together with load_valid.
- busy  out  1  high in the FETCH and RESP states.

## Operation
- States:
  - IDLE: arbitrate requests.
  - FETCH: read one byte per cycle; byte counter cnt runs 0..NB-1.
  - RESP: assert fetch_valid for one cycle.
- IDLE arbitration. fetch_ready and load_ready are combinational and asserted only in IDLE:
  - Only fetch_req: fetch_ready=1 and the fetch is accepted. fetch_addr[ADDR_BITS-1:0] is captured into base, cnt clears, and the state moves to FETCH.
  - Only load_valid: load_ready=1 and mem[load_addr] <= load_data at this edge. The state stays IDLE, so back-to-back writes run at one per cycle.
  - Both requests: a round-robin priority bit decides. The winner gets its ready and the loser's ready is 0. After each grant the priority bit points at the other requester. After reset, fetch has priority.
  - Single-requester grants also update the priority bit.
- FETCH:
  - Each cycle, read mem[(base+cnt) mod DEPTH] and shift it into the assembly register MSB-first: asm <= {asm[REG_BITS-9:0], byte}.
  - The first byte read (cnt=0) ends up in bits [REG_BITS-1:REG_BITS-8].
  - When cnt==NB-1, move to RESP.
- RESP:
  - fetch_instr <= asm is registered on entry, so fetch_instr is valid during RESP.
  - fetch_valid=1 for this cycle only, then return to IDLE.
- Address arithmetic is ADDR_BITS wide with natural wrap: a fetch at DEPTH-1 reads DEPTH-1, 0, 1, ...
- Misaligned fetch addresses are legal; no alignment checks are made.
- Loads are refused (load_ready=0) in FETCH and RESP. The loader must hold load_valid until it sees load_ready.
- fetch_req is ignored outside IDLE, and fetch_addr is sampled only at acceptance.
- Array contents are not affected by reset and are undefined until written.

## Timing
- Reset values: state=IDLE, fetch_valid=0, fetch_instr=0, busy=0, priority=fetch. fetch_ready and load_ready follow the IDLE rules in the first cycle after reset.
- Fetch accepted in cycle T:
  - FETCH occupies cycles T+1..T+NB.
  - fetch_valid=1 in cycle T+NB+1.
  - IDLE in T+NB+2, which is the earliest next acceptance.
  - Latency: NB+1 cycles from acceptance to data (5 for REG_BITS=32). Peak throughput is one fetch per NB+2 cycles.
- Load write: 0-cycle handshake, data written at the accepting edge. A fetch accepted in the next cycle reads the new byte.
- Reset asserted mid-FETCH or in RESP:
  - The transaction is aborted and no fetch_valid is produced.
  - fetch_instr clears to 0.
  - Bytes already written are preserved.
- Reset asserted together with requests: no handshake occurs in that cycle.

## Test plan
- Load 0xDE,0xAD,0xBE,0xEF at 0x10..0x13, then fetch 0x10 accepted in cycle T -> fetch_valid only in T+5, fetch_instr=0xDEADBEEF; busy high in T+1..T+5.
- Wrap: load 0x11,0x22,0x33,0x44 at 0xFE,0xFF,0x00,0x01, then fetch 0xFE -> 0x11223344. Fetch_addr 0x1FE (upper bits set) gives the same result.
- Contention: hold fetch_req and load_valid high continuously from reset. Required sequence:
  - fetch granted first;
  - load granted at the first IDLE after RESP;
  - then grants alternate between fetch and load.
  - load_ready must be 0 in every FETCH/RESP cycle.
- Reset asserted in the second FETCH cycle -> no fetch_valid, fetch_instr=0, state IDLE. A refetch of the same address returns the pre-reset contents.
- REG_BITS=16: bytes 0xAB,0xCD at 0x21, fetch 0x21 (misaligned) -> fetch_instr=0xABCD, fetch_valid at acceptance+3.
- Back-to-back loads on 8 consecutive cycles -> all eight written with no stalls. A fetch over them then returns the stored bytes in MSB-first order.
